id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register for the 5-stage RV32 core. Sits directly downstream of the
//  register file: captures rs1/rs2 read data (valid before posedge; the file drives it on negedge)
//  plus decoded fields, and presents them to EX.
//  Also applies a WB->ID same-cycle bypass, detects load-use hazards and inserts bubbles.
//  Honours hold (back-pressure) and flush (redirect) requests from later stages.
// PARAMETERS
//  XLEN    32  datapath width
//  CTRL_W  8   width of opaque ALU/branch control bundle, passed through unchanged
//  CNT_W   16  width of saturating bubble counter
// PORTS
//  clock         in   1       pipeline clock, rising edge
//  reset         in   1       asynchronous, active-high; clears all state
//  id_valid      in   1       decode slot holds a real instruction
//  id_pc         in   XLEN    instruction PC
//  id_rs1        in   5       source reg 1 address (also drives register file read_address_1)
//  id_rs2        in   5       source reg 2 address
//  id_use_rs2    in   1       instruction actually reads rs2 (R/S/B types)
//  id_rd         in   5       destination register
//  id_imm        in   XLEN    sign-extended immediate
//  id_ctrl       in   CTRL_W  ALU/branch control bundle
//  id_reg_write  in   1       writes rd
//  id_mem_read   in   1       load
//  id_mem_write  in   1       store
//  rf_data_1     in   XLEN    register file data for id_rs1
//  rf_data_2     in   XLEN    register file data for id_rs2
//  wb_write      in   1       WB stage writing register file this cycle
//  wb_address    in   5       WB destination
//  wb_data       in   XLEN    WB data
//  hold          in   1       EX cannot accept; freeze stage
//  flush         in   1       kill instruction entering EX (branch/jump redirect)
//  stall_req     out  1       comb: freeze PC and IF/ID this cycle (load-use)
//  ex_valid      out  1       EX slot holds a real instruction
//  ex_pc, ex_imm out  XLEN    registered copies
//  ex_rs1,ex_rs2,ex_rd out 5  registered addresses (consumed by EX forwarding)
//  ex_op_a, ex_op_b out XLEN  registered operands after WB bypass
//  ex_ctrl       out  CTRL_W  registered control bundle
//  ex_reg_write, ex_mem_read, ex_mem_write  out 1  registered, forced 0 when !ex_valid
//  bubble_count  out  CNT_W   saturating count of bubbles inserted by load-use or flush
// BEHAVIOUR
//  Reset (async): every registered output = 0, bubble_count = 0; stall_req evaluates low (ex_valid=0).
//  Bypass (comb): op_a_n = (wb_write && wb_address==id_rs1 && id_rs1!=0) ? wb_data : rf_data_1; same rule for op_b_n with rs2.
//    x0 always reads 0 regardless of rf_data.
//  Load-use: lu = id_valid && ex_valid && ex_mem_read && ex_rd!=0 &&
//    (ex_rd==id_rs1 || (id_use_rs2 && ex_rd==id_rs2)); stall_req = lu && !flush && !hold.
//  Per posedge, first match wins:
//    1 flush         -> bubble: ex_valid,ex_reg_write,ex_mem_read,ex_mem_write=0, other fields 0; count++
//    2 hold          -> all ex_* unchanged; stall_req forced 0 (upstream held by hold path)
//    3 lu            -> bubble as in 1; IF/ID retains instruction, reissues next cycle; count++
//    4 otherwise     -> load all id_* fields; ex_valid=id_valid; side-effect bits ANDed with id_valid
//  Latency 1 cycle ID->EX. Load-use costs exactly one bubble; next cycle lu is false (ex is bubble).
//  bubble_count saturates at all-ones, never wraps. Bubbles from id_valid=0 are not counted.
//  Flush with hold: flush wins (redirected instruction must never execute).
//  Reset asserted mid-operation: outputs clear immediately, no clock needed.
// STRUCTURE
//  Shared package rv_pipe_pkg: XLEN, REG_ADDR_W=5, X0 constant, CTRL_W, bubble/nop field constants.
//  One sub-module: hazard_detect (pure comb lu/stall_req); bypass mux and register kept in top.
// TESTING
//  Reset mid-stream with ex_valid=1 -> all outputs 0 asynchronously, bubble_count=0.
//  lw x5 in EX, add x6,x5,x1 in ID -> stall_req=1 one cycle, bubble, add enters EX next cycle, count=1.
//  wb_write=1,wb_address=3,wb_data=0xDEADBEEF, id_rs1=3, rf_data_1=0 -> ex_op_a=0xDEADBEEF next cycle.
//  id_rs2=0 with wb_address=0,wb_data=5, rf_data_2=7 -> ex_op_b=0.
//  hold=1 for 3 cycles with changing id_* -> ex_* frozen; flush=1 with hold=1 -> bubble, count increments.
//  Force bubble_count to 0xFFFF, then flush -> stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared RV32 pipeline constants and the ID/EX slot layout.
// Imported by the ID/EX register, its hazard detector and its interface.
package rv_pipe_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;
  localparam int CNT_W      = 16;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [CTRL_W-1:0]     ctrl;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_slot_t;

  // A bubble is an all-zero slot: invalid and with no side effects.
  localparam ex_slot_t EX_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode/regfile/WB/control and the ID/EX register.
// slave = the stage itself, master = whoever drives decode and observes EX.
interface id_ex_stage_if;
  import rv_pipe_pkg::*;

  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [XLEN-1:0]       id_imm;
  logic [CTRL_W-1:0]     id_ctrl;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic [XLEN-1:0]       rf_data_1;
  logic [XLEN-1:0]       rf_data_2;
  logic                  wb_write;
  logic [REG_ADDR_W-1:0] wb_address;
  logic [XLEN-1:0]       wb_data;
  logic                  hold;
  logic                  flush;

  logic                  stall_req;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       ex_op_a;
  logic [XLEN-1:0]       ex_op_b;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [CNT_W-1:0]      bubble_count;

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs2, id_rd, id_imm, id_ctrl,
           id_reg_write, id_mem_read, id_mem_write, rf_data_1, rf_data_2,
           wb_write, wb_address, wb_data, hold, flush,
    output stall_req, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_op_a,
           ex_op_b, ex_ctrl, ex_reg_write, ex_mem_read, ex_mem_write, bubble_count
  );

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs2, id_rd, id_imm, id_ctrl,
           id_reg_write, id_mem_read, id_mem_write, rf_data_1, rf_data_2,
           wb_write, wb_address, wb_data, hold, flush,
    input  stall_req, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_op_a,
           ex_op_b, ex_ctrl, ex_reg_write, ex_mem_read, ex_mem_write, bubble_count
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose rd is read by the instruction in ID.
// Purely combinational; the stall request is masked when flush or hold already governs upstream.
module hazard_detect
  import rv_pipe_pkg::*;
(
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs2_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic                  lu_o,
    output logic                  stall_req_o
);
    assign lu_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != X0) &&
                  ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));

    assign stall_req_o = lu_o && !flush_i && !hold_i;
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with WB same-cycle bypass, load-use bubbling,
// hold/flush handling and a saturating bubble counter.
module id_ex_stage
  import rv_pipe_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    ex_slot_t         slot_q, slot_d, id_slot;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;

    // The register file cannot see a write landing this same cycle, so WB wins over it; x0 is hardwired.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] wa,
        input logic [XLEN-1:0]       wd,
        input logic [XLEN-1:0]       rf
    );
        if (rs == X0)             return '0;
        else if (wr && (wa == rs)) return wd;
        else                      return rf;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    hazard_detect u_hazard (
        .id_valid_i    (bus.id_valid),
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_use_rs2_i  (bus.id_use_rs2),
        .ex_valid_i    (slot_q.valid),
        .ex_mem_read_i (slot_q.mem_read),
        .ex_rd_i       (slot_q.rd),
        .flush_i       (bus.flush),
        .hold_i        (bus.hold),
        .lu_o          (lu),
        .stall_req_o   (bus.stall_req)
    );

    always_comb begin
        id_slot           = EX_BUBBLE;
        id_slot.valid     = bus.id_valid;
        id_slot.pc        = bus.id_pc;
        id_slot.rs1       = bus.id_rs1;
        id_slot.rs2       = bus.id_rs2;
        id_slot.rd        = bus.id_rd;
        id_slot.imm       = bus.id_imm;
        id_slot.op_a      = read_operand(bus.id_rs1, bus.wb_write, bus.wb_address,
                                         bus.wb_data, bus.rf_data_1);
        id_slot.op_b      = read_operand(bus.id_rs2, bus.wb_write, bus.wb_address,
                                         bus.wb_data, bus.rf_data_2);
        id_slot.ctrl      = bus.id_ctrl;
        id_slot.reg_write = bus.id_reg_write && bus.id_valid;
        id_slot.mem_read  = bus.id_mem_read  && bus.id_valid;
        id_slot.mem_write = bus.id_mem_write && bus.id_valid;
    end

    // Priority: flush beats hold so a redirected instruction never executes.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (bus.flush) begin
            slot_d = EX_BUBBLE;
            cnt_d  = sat_inc(cnt_q);
        end else if (bus.hold) begin
            slot_d = slot_q;
        end else if (lu) begin
            slot_d = EX_BUBBLE;
            cnt_d  = sat_inc(cnt_q);
        end else begin
            slot_d = id_slot;
        end
    end

    // ---- ID/EX boundary ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q <= EX_BUBBLE;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.ex_valid     = slot_q.valid;
    assign bus.ex_pc        = slot_q.pc;
    assign bus.ex_imm       = slot_q.imm;
    assign bus.ex_rs1       = slot_q.rs1;
    assign bus.ex_rs2       = slot_q.rs2;
    assign bus.ex_rd        = slot_q.rd;
    assign bus.ex_op_a      = slot_q.op_a;
    assign bus.ex_op_b      = slot_q.op_b;
    assign bus.ex_ctrl      = slot_q.ctrl;
    assign bus.ex_reg_write = slot_q.reg_write;
    assign bus.ex_mem_read  = slot_q.mem_read;
    assign bus.ex_mem_write = slot_q.mem_write;
    assign bus.bubble_count = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, bypass, load-use, hold/flush, saturation.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid     = 1'b0;
    bus.id_pc        = '0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_use_rs2   = 1'b0;
    bus.id_rd        = '0;
    bus.id_imm       = '0;
    bus.id_ctrl      = '0;
    bus.id_reg_write = 1'b0;
    bus.id_mem_read  = 1'b0;
    bus.id_mem_write = 1'b0;
    bus.rf_data_1    = '0;
    bus.rf_data_2    = '0;
    bus.wb_write     = 1'b0;
    bus.wb_address   = '0;
    bus.wb_data      = '0;
    bus.hold         = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic use_rs2, input logic [31:0] imm,
                             input logic [7:0] ctrl, input logic rw, input logic mr, input logic mw,
                             input logic [31:0] d1, input logic [31:0] d2);
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_use_rs2   = use_rs2;
    bus.id_imm       = imm;
    bus.id_ctrl      = ctrl;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.rf_data_1    = d1;
    bus.rf_data_2    = d2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%h exp=0", bus.ex_valid); end
    checks++; if (bus.ex_pc !== 32'h0) begin failures++; $display("FAIL reset_ex_pc got=%h exp=0", bus.ex_pc); end
    checks++; if (bus.ex_op_a !== 32'h0) begin failures++; $display("FAIL reset_ex_op_a got=%h exp=0", bus.ex_op_a); end
    checks++; if (bus.bubble_count !== 16'h0) begin failures++; $display("FAIL reset_bubble_count got=%h exp=0", bus.bubble_count); end
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall_req got=%h exp=0", bus.stall_req); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_basic_load();
    drive_instr(32'h100, 5'd1, 5'd2, 5'd4, 1'b1, 32'h10, 8'hA5, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'h22222222);
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL basic_ex_valid got=%h exp=1", bus.ex_valid); end
    checks++; if (bus.ex_pc !== 32'h100) begin failures++; $display("FAIL basic_ex_pc got=%h exp=100", bus.ex_pc); end
    checks++; if (bus.ex_op_a !== 32'h11111111) begin failures++; $display("FAIL basic_op_a got=%h exp=11111111", bus.ex_op_a); end
    checks++; if (bus.ex_op_b !== 32'h22222222) begin failures++; $display("FAIL basic_op_b got=%h exp=22222222", bus.ex_op_b); end
    checks++; if (bus.ex_imm !== 32'h10) begin failures++; $display("FAIL basic_imm got=%h exp=10", bus.ex_imm); end
    checks++; if (bus.ex_ctrl !== 8'hA5) begin failures++; $display("FAIL basic_ctrl got=%h exp=a5", bus.ex_ctrl); end
    checks++; if (bus.ex_rs1 !== 5'd1 || bus.ex_rs2 !== 5'd2 || bus.ex_rd !== 5'd4) begin failures++; $display("FAIL basic_addrs got=%0d/%0d/%0d exp=1/2/4", bus.ex_rs1, bus.ex_rs2, bus.ex_rd); end
    checks++; if (bus.ex_reg_write !== 1'b1 || bus.ex_mem_read !== 1'b0) begin failures++; $display("FAIL basic_side got=%b%b exp=10", bus.ex_reg_write, bus.ex_mem_read); end
    drive_instr(32'h104, 5'd1, 5'd2, 5'd4, 1'b1, 32'h10, 8'hA5, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2);
    bus.id_valid = 1'b0;
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL invalid_ex_valid got=%h exp=0", bus.ex_valid); end
    checks++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 3'b000) begin failures++; $display("FAIL invalid_side got=%b%b%b exp=000", bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write); end
    checks++; if (bus.bubble_count !== 16'd0) begin failures++; $display("FAIL invalid_not_counted got=%0d exp=0", bus.bubble_count); end
  endtask

  task automatic test_bypass();
    drive_instr(32'h108, 5'd3, 5'd2, 5'd7, 1'b1, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h22);
    bus.wb_write = 1'b1; bus.wb_address = 5'd3; bus.wb_data = 32'hDEADBEEF;
    tick();
    checks++; if (bus.ex_op_a !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", bus.ex_op_a); end
    checks++; if (bus.ex_op_b !== 32'h22) begin failures++; $display("FAIL bypass_rs2_nomatch got=%h exp=22", bus.ex_op_b); end
    drive_instr(32'h10C, 5'd4, 5'd0, 5'd7, 1'b1, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h7);
    bus.wb_address = 5'd0; bus.wb_data = 32'h5;
    tick();
    checks++; if (bus.ex_op_b !== 32'h0) begin failures++; $display("FAIL bypass_x0 got=%h exp=0", bus.ex_op_b); end
    checks++; if (bus.ex_op_a !== 32'h44) begin failures++; $display("FAIL bypass_rf_a got=%h exp=44", bus.ex_op_a); end
    drive_instr(32'h110, 5'd4, 5'd2, 5'd7, 1'b1, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h99);
    bus.wb_address = 5'd2; bus.wb_data = 32'h55;
    tick();
    checks++; if (bus.ex_op_b !== 32'h55) begin failures++; $display("FAIL bypass_rs2 got=%h exp=55", bus.ex_op_b); end
    bus.wb_write = 1'b0;
    tick();
    checks++; if (bus.ex_op_b !== 32'h99) begin failures++; $display("FAIL bypass_nowrite got=%h exp=99", bus.ex_op_b); end
  endtask

  task automatic test_load_use();
    drive_instr(32'h200, 5'd1, 5'd0, 5'd5, 1'b0, 32'h4, 8'h0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    checks++; if (bus.ex_mem_read !== 1'b1) begin failures++; $display("FAIL lu_load_in_ex got=%h exp=1", bus.ex_mem_read); end
    drive_instr(32'h204, 5'd5, 5'd1, 5'd6, 1'b1, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h50, 32'h1);
    #1;
    checks++; if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL lu_stall_req got=%h exp=1", bus.stall_req); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b%b exp=00", bus.ex_valid, bus.ex_mem_read); end
    checks++; if (bus.bubble_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", bus.bubble_count); end
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL lu_one_bubble got=%h exp=0", bus.stall_req); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.ex_pc !== 32'h204) begin failures++; $display("FAIL lu_reissue got=%b/%0d/%h exp=1/6/204", bus.ex_valid, bus.ex_rd, bus.ex_pc); end
    checks++; if (bus.bubble_count !== 16'd1) begin failures++; $display("FAIL lu_count_hold got=%0d exp=1", bus.bubble_count); end
    drive_instr(32'h208, 5'd1, 5'd0, 5'd7, 1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    drive_instr(32'h20C, 5'd1, 5'd7, 5'd8, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL lu_rs2_unused got=%h exp=0", bus.stall_req); end
    bus.id_use_rs2 = 1'b1;
    #1;
    checks++; if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL lu_rs2_used got=%h exp=1", bus.stall_req); end
    bus.hold = 1'b1;
    #1;
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL lu_hold_mask got=%h exp=0", bus.stall_req); end
    bus.hold = 1'b0;
    tick();
    checks++; if (bus.bubble_count !== 16'd2 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL lu_rs2_bubble got=%0d/%b exp=2/0", bus.bubble_count, bus.ex_valid); end
    set_idle();
    tick();
  endtask

  task automatic test_hold_flush();
    drive_instr(32'h300, 5'd1, 5'd2, 5'd9, 1'b1, 32'h30, 8'h3C, 1'b1, 1'b0, 1'b0, 32'hAA, 32'hBB);
    tick();
    checks++; if (bus.ex_pc !== 32'h300) begin failures++; $display("FAIL hold_setup got=%h exp=300", bus.ex_pc); end
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc = 32'h400 + 32'(i * 4);
      bus.id_rs1 = 5'(10 + i);
      bus.rf_data_1 = 32'(i);
      bus.id_ctrl = 8'(i);
      tick();
      checks++; if (bus.ex_pc !== 32'h300 || bus.ex_op_a !== 32'hAA || bus.ex_ctrl !== 8'h3C) begin failures++; $display("FAIL hold_frozen_%0d got=%h/%h/%h exp=300/aa/3c", i, bus.ex_pc, bus.ex_op_a, bus.ex_ctrl); end
    end
    checks++; if (bus.bubble_count !== 16'd2) begin failures++; $display("FAIL hold_count got=%0d exp=2", bus.bubble_count); end
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_reg_write !== 1'b0) begin failures++; $display("FAIL flush_over_hold got=%b/%h/%b exp=0/0/0", bus.ex_valid, bus.ex_pc, bus.ex_reg_write); end
    checks++; if (bus.bubble_count !== 16'd3) begin failures++; $display("FAIL flush_count got=%0d exp=3", bus.bubble_count); end
    bus.hold = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    drive_instr(32'h500, 5'd1, 5'd2, 5'd3, 1'b1, 32'h5, 8'h11, 1'b1, 1'b0, 1'b1, 32'h123, 32'h456);
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL mid_setup got=%h exp=1", bus.ex_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_op_a !== 32'h0 || bus.ex_mem_write !== 1'b0) begin failures++; $display("FAIL mid_reset_outputs got=%b/%h/%h/%b exp=0/0/0/0", bus.ex_valid, bus.ex_pc, bus.ex_op_a, bus.ex_mem_write); end
    checks++; if (bus.bubble_count !== 16'd0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", bus.bubble_count); end
    reset = 1'b0;
    set_idle();
    #1;
  endtask

  task automatic test_saturation();
    drive_instr(32'h600, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.bubble_count !== 16'd1) begin failures++; $display("FAIL sat_first got=%0d exp=1", bus.bubble_count); end
    repeat (65534) @(posedge clock);
    #1;
    checks++; if (bus.bubble_count !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", bus.bubble_count); end
    repeat (3) tick();
    checks++; if (bus.bubble_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", bus.bubble_count); end
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL sat_bubble got=%h exp=0", bus.ex_valid); end
    set_idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_load();
    test_bypass();
    test_load_use();
    test_hold_flush();
    test_reset_midstream();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
